lfsr_ctrl_axil_responder: RTL and testbench
===========================================

# lfsr_ctrl_axil_responder

AXI-Lite responder (slave) holding the LFSR histogram generator's control and status registers. It accepts the write/read transactions issued by the system's AXI-Lite initiator, produces the start/stop pulses and the seed/taps configuration for the LFSR, and returns run status and the sample count on reads. It sits between the AXI-Lite interconnect and the LFSR/histogram datapath inside the histogram system top.

## Interface
- AXIL_ADDR_WIDTH, 4, AXI-Lite address width; only addr[3:2] decoded.
- AXIL_DATA_WIDTH, 32, AXI-Lite data width.
- LFSR_WIDTH, 8, width of seed/taps registers.
- CNT_WIDTH, 16, width of the sample count input.

Reset is synchronous, active-high, named `areset`; single clock `aclk`.

- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous reset, active-high.
- s_axi_awaddr / s_axi_awvalid / s_axi_awready  in/in/out  AXIL_ADDR_WIDTH/1/1  write address channel.
- s_axi_wdata / s_axi_wvalid / s_axi_wready  in/in/out  AXIL_DATA_WIDTH/1/1  write data channel.
- s_axi_bresp / s_axi_bvalid / s_axi_bready  out/out/in  2/1/1  write response channel.
- s_axi_araddr / s_axi_arvalid / s_axi_arready  in/in/out  AXIL_ADDR_WIDTH/1/1  read address channel.
- s_axi_rdata / s_axi_rresp / s_axi_rvalid / s_axi_rready  out/out/out/in  AXIL_DATA_WIDTH/2/1/1  read data channel.
- lfsr_start  out  1  one-cycle start pulse to LFSR.
- lfsr_stop  out  1  one-cycle stop pulse to LFSR.
- lfsr_seed  out  LFSR_WIDTH  seed register.
- lfsr_taps  out  LFSR_WIDTH  tap mask register.
- sample_cnt  in  CNT_WIDTH  samples produced since last start.

## Operation
- Register map (addr[3:2]): 0x0 CTRL_START, 0x4 CTRL_STOP, 0x8 SEED, 0xC TAPS. addr[1:0] ignored.
- Internal `running` flag, reset 0.
- Write 0x0 with wdata[0]=1 and running=0: lfsr_start pulses, running←1. Any other 0x0 write: no effect, OKAY.
- Write 0x4 with wdata[0]=1 and running=1: lfsr_stop pulses, running←0. Otherwise no effect, OKAY.
- Write 0x8: seed←wdata[LFSR_WIDTH-1:0]; value 0 stored as 0x01 (avoids LFSR lockup). Write 0xC: taps←wdata[LFSR_WIDTH-1:0].
- Reads: 0x0 → {31'b0, running}; 0x4 → zero-extended sample_cnt sampled at AR handshake; 0x8 → zero-extended seed; 0xC → zero-extended taps. rresp always 00.
- Write FSM: AW and W captured independently into holding registers; AW may precede W, follow it, or arrive in the same cycle. Commit occurs on the edge where both are present (held or handshaking); bvalid asserts the next cycle.

## Timing
- Reset values: all ready/valid outputs 0 during reset, then awready=wready=arready=1 in the first cycle after reset; bresp=00, rresp=00, rdata=0, lfsr_start=lfsr_stop=0, lfsr_seed=0x01, lfsr_taps=0x8E.
- awready = !aw_held & !bvalid; wready = !w_held & !bvalid. At most one outstanding write.
- Write latency: lfsr_start/lfsr_stop/register update on the commit edge; bvalid high one cycle after commit, held with stable bresp until bready; holding registers cleared at B handshake.
- arready = !rvalid. AR handshake → rvalid the next cycle, rdata/rresp stable until rready. One outstanding read.
- Reads and writes are independent and may complete in the same cycle; a read of 0x0 in the commit cycle of a START write returns the pre-write running value.
- areset mid-transaction: all held AW/W, bvalid, rvalid dropped; no pulse issued; registers return to reset values.

## Configuration
- LFSR_CTRL_SEED_GUARD_EN defined: writes to 0x8/0xC while running=1 are rejected — registers unchanged, bresp=10 (SLVERR).
- Not defined: such writes are accepted with bresp=00; new values reach the LFSR on its next start.

## Test plan
- Reset, then read 0x8 and 0xC → rdata 0x01 and 0x8E, rresp 00; read 0x0 → 0.
- Write 0x8=0x01, 0xC=0x8E, 0x0=0x01 → one-cycle lfsr_start, read 0x0 → 1; second 0x0 write → no pulse, bresp 00.
- AW issued 3 cycles before W, then W before AW, then both in the same cycle, each with bready held low 2 cycles → single commit each, bvalid held until bready.
- With sample_cnt=0x01F4, read 0x4 → 0x000001F4; write 0x4=0x01 → lfsr_stop pulse, running 0.
- Write 0x8=0x00 → readback 0x01. With guard macro and running=1, write 0x8=0x55 → bresp 10, readback unchanged; without macro → bresp 00, readback 0x55.
- Assert areset while bvalid pending → bvalid drops, registers return to 0x01/0x8E, running 0.

Source files
------------

// File: rtl/lfsr_ctrl_axil_responder.sv
// AXI-Lite control/status responder for the LFSR histogram generator.
// Optional LFSR_CTRL_SEED_GUARD_EN: reject SEED/TAPS writes while running.
module lfsr_ctrl_axil_responder #(
  parameter int AXIL_ADDR_WIDTH = 4,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int LFSR_WIDTH      = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [AXIL_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [AXIL_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic                       lfsr_start,
  output logic                       lfsr_stop,
  output logic [LFSR_WIDTH-1:0]      lfsr_seed,
  output logic [LFSR_WIDTH-1:0]      lfsr_taps,
  input  logic [CNT_WIDTH-1:0]       sample_cnt
);

  localparam logic [LFSR_WIDTH-1:0] SEED_RST = LFSR_WIDTH'(1);
  localparam logic [LFSR_WIDTH-1:0] TAPS_RST = LFSR_WIDTH'(8'h8E);

  logic                       r_aw_held;
  logic [1:0]                 r_aw_addr;
  logic                       r_w_held;
  logic [LFSR_WIDTH-1:0]      r_w_data;
  logic                       r_bvalid;
  logic [1:0]                 r_bresp;
  logic                       r_rvalid;
  logic [AXIL_DATA_WIDTH-1:0] r_rdata;
  logic                       r_running;
  logic                       r_start;
  logic                       r_stop;
  logic [LFSR_WIDTH-1:0]      r_seed;
  logic [LFSR_WIDTH-1:0]      r_taps;

  logic                       w_aw_hs;
  logic                       w_w_hs;
  logic                       w_ar_hs;
  logic                       w_commit;
  logic                       w_reject;
  logic [1:0]                 w_addr;
  logic [LFSR_WIDTH-1:0]      w_data;
  logic [AXIL_DATA_WIDTH-1:0] w_rd_data;
  logic                       w_unused;

  assign s_axi_awready = !areset && !r_aw_held && !r_bvalid;
  assign s_axi_wready  = !areset && !r_w_held && !r_bvalid;
  assign s_axi_arready = !areset && !r_rvalid;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;
  assign lfsr_start    = r_start;
  assign lfsr_stop     = r_stop;
  assign lfsr_seed     = r_seed;
  assign lfsr_taps     = r_taps;

  assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_w_hs   = s_axi_wvalid && s_axi_wready;
  assign w_ar_hs  = s_axi_arvalid && s_axi_arready;
  assign w_addr   = r_aw_held ? r_aw_addr : s_axi_awaddr[3:2];
  assign w_data   = r_w_held ? r_w_data : s_axi_wdata[LFSR_WIDTH-1:0];
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)
                    && !r_bvalid;

`ifdef LFSR_CTRL_SEED_GUARD_EN
  assign w_reject = w_addr[1] && r_running;
`else
  assign w_reject = 1'b0;
`endif

  assign w_unused = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                      s_axi_wdata[AXIL_DATA_WIDTH-1:LFSR_WIDTH]};

  always_comb begin
    w_rd_data = '0;
    case (s_axi_araddr[3:2])
      2'd0:    w_rd_data[0]             = r_running;
      2'd1:    w_rd_data[CNT_WIDTH-1:0] = sample_cnt;
      2'd2:    w_rd_data[LFSR_WIDTH-1:0] = r_seed;
      default: w_rd_data[LFSR_WIDTH-1:0] = r_taps;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= 2'd0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_running <= 1'b0;
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
      r_seed    <= SEED_RST;
      r_taps    <= TAPS_RST;
    end else begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s_axi_awaddr[3:2];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= s_axi_wdata[LFSR_WIDTH-1:0];
      end
      // Holding regs stay set until B completes to block a second write.
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_reject ? 2'b10 : 2'b00;
        if (!w_reject) begin
          case (w_addr)
            2'd0: if (w_data[0] && !r_running) begin
              r_start   <= 1'b1;
              r_running <= 1'b1;
            end
            2'd1: if (w_data[0] && r_running) begin
              r_stop    <= 1'b1;
              r_running <= 1'b0;
            end
            2'd2: r_seed <= (w_data == '0) ? SEED_RST : w_data;
            default: r_taps <= w_data;
          endcase
        end
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid  <= 1'b0;
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (r_rvalid && s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_ctrl_axil_responder.sv
// Bench for lfsr_ctrl_axil_responder: directed plus random AXI-Lite
// traffic against a register-level reference model.
module tb_lfsr_ctrl_axil_responder;

`ifdef LFSR_CTRL_SEED_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        lfsr_start;
  logic        lfsr_stop;
  logic [7:0]  lfsr_seed;
  logic [7:0]  lfsr_taps;
  logic [15:0] sample_cnt = '0;

  always #5 aclk = ~aclk;

  lfsr_ctrl_axil_responder dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .lfsr_start(lfsr_start), .lfsr_stop(lfsr_stop),
    .lfsr_seed(lfsr_seed), .lfsr_taps(lfsr_taps),
    .sample_cnt(sample_cnt)
  );

  int errors = 0;
  int checks = 0;
  int n_start = 0;
  int n_stop = 0;

  always @(posedge aclk) begin
    if (lfsr_start) n_start++;
    if (lfsr_stop) n_stop++;
  end

  // Reference model: register file state only.
  bit         m_run = 1'b0;
  logic [7:0] m_seed = 8'h01;
  logic [7:0] m_taps = 8'h8E;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d,
                             output logic [1:0] r, output int s,
                             output int p);
    r = 2'b00; s = 0; p = 0;
    case (a[3:2])
      2'd0: if (d[0] && !m_run) begin s = 1; m_run = 1'b1; end
      2'd1: if (d[0] && m_run) begin p = 1; m_run = 1'b0; end
      default: begin
        if (GUARD && m_run) r = 2'b10;
        else if (a[2]) m_taps = d[7:0];
        else m_seed = (d[7:0] == 8'h00) ? 8'h01 : d[7:0];
      end
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0: return {31'b0, m_run};
      2'd1: return {16'b0, sample_cnt};
      2'd2: return {24'b0, m_seed};
      default: return {24'b0, m_taps};
    endcase
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [31:0] d,
                          input int aw_d, input int w_d, input int b_d);
    logic [1:0] er;
    int es, ep, s0, p0, t;
    bit aw_done, w_done, aw_f, w_f;
    model_write(a, d, er, es, ep);
    s0 = n_start; p0 = n_stop;
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 50) begin
      @(negedge aclk);
      awaddr  = a;
      wdata   = d;
      awvalid = !aw_done && (t >= aw_d);
      wvalid  = !w_done && (t >= w_d);
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(posedge aclk);
      if (aw_f) aw_done = 1;
      if (w_f) w_done = 1;
      t++;
    end
    if (!(aw_done && w_done)) check("wr_handshake_timeout", 0, 1);
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("bvalid_after_commit", bvalid, 1);
    check("start_on_commit", lfsr_start, es);
    check("stop_on_commit", lfsr_stop, ep);
    for (int k = 0; k < b_d; k++) begin
      check("bvalid_held", bvalid, 1);
      check("awready_blocked", awready, 0);
      @(negedge aclk);
    end
    bready = 1'b1;
    check("bvalid_at_b", bvalid, 1);
    check("bresp", bresp, er);
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_cleared", bvalid, 0);
    check("start_count", n_start - s0, es);
    check("stop_count", n_stop - p0, ep);
    check("seed_port", lfsr_seed, m_seed);
    check("taps_port", lfsr_taps, m_taps);
  endtask

  task automatic do_read(input logic [3:0] a, input int r_d);
    logic [31:0] exp;
    int n;
    @(negedge aclk);
    araddr  = a;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (!arready) check("ar_timeout", 0, 1);
    exp = model_read(a);
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
    check("rvalid_after_ar", rvalid, 1);
    for (int k = 0; k < r_d; k++) begin
      @(negedge aclk);
      check("rvalid_held", rvalid, 1);
    end
    rready = 1'b1;
    check($sformatf("rdata_%h", a), rdata, exp);
    check("rresp", rresp, 2'b00);
    @(negedge aclk);
    rready = 1'b0;
    check("rvalid_cleared", rvalid, 0);
  endtask

  initial begin
    logic [3:0]  ra;
    logic [31:0] rd;

    areset = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    areset = 1'b0;
    @(negedge aclk);
    check("post_awready", awready, 1);
    check("post_wready", wready, 1);
    check("post_arready", arready, 1);
    check("post_rdata", rdata, 0);
    check("post_bresp", bresp, 0);
    check("post_start", lfsr_start, 0);
    check("post_seed", lfsr_seed, 8'h01);
    check("post_taps", lfsr_taps, 8'h8E);

    do_read(4'h8, 0);
    do_read(4'hC, 1);
    do_read(4'h0, 0);

    do_write(4'h8, 32'h01, 0, 0, 0);
    do_write(4'hC, 32'h8E, 0, 0, 0);
    do_write(4'h0, 32'h01, 0, 0, 0);
    do_read(4'h0, 0);
    do_write(4'h0, 32'h01, 0, 0, 1);

    do_write(4'hC, 32'hA3, 0, 3, 2);
    do_write(4'h9, 32'h4C, 3, 0, 2);
    do_write(4'h2, 32'h00, 1, 1, 2);

    sample_cnt = 16'h01F4;
    do_read(4'h4, 0);
    do_write(4'h4, 32'h01, 0, 0, 0);
    do_read(4'h0, 0);

    do_write(4'h8, 32'h00, 0, 0, 0);
    do_read(4'h8, 0);
    do_write(4'h0, 32'h01, 0, 0, 0);
    do_write(4'h8, 32'h55, 0, 0, 0);
    do_read(4'h8, 0);
    do_write(4'h4, 32'h01, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      ra = 4'($urandom);
      sample_cnt = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        do_read(ra, $urandom_range(0, 2));
      end else begin
        rd = $urandom;
        if ($urandom_range(0, 1) == 1) rd[0] = 1'b1;
        if ($urandom_range(0, 7) == 0) rd = 32'h0;
        do_write(ra, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      end
    end

    // Ensure stopped, then START write and status read share an edge.
    if (m_run) do_write(4'h4, 32'h01, 0, 0, 0);
    @(negedge aclk);
    awaddr = 4'h0; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h0; arvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    m_run = 1'b1;
    check("same_cycle_start", lfsr_start, 1);
    check("same_cycle_bvalid", bvalid, 1);
    check("same_cycle_rvalid", rvalid, 1);
    check("same_cycle_pre_run", rdata, 0);
    bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    bready = 1'b0; rready = 1'b0;
    check("same_cycle_b_done", bvalid, 0);
    check("same_cycle_r_done", rvalid, 0);
    do_read(4'h0, 0);

    // Reset with a write response pending.
    @(negedge aclk);
    awaddr = 4'h8; wdata = 32'h33; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("pending_bvalid", bvalid, 1);
    areset = 1'b1;
    @(negedge aclk);
    check("rst_mid_bvalid", bvalid, 0);
    check("rst_mid_awready", awready, 0);
    check("rst_mid_seed", lfsr_seed, 8'h01);
    check("rst_mid_taps", lfsr_taps, 8'h8E);
    check("rst_mid_stop", lfsr_stop, 0);
    areset = 1'b0;
    m_run = 1'b0; m_seed = 8'h01; m_taps = 8'h8E;
    @(negedge aclk);
    check("rst_mid_wready", wready, 1);
    do_read(4'h0, 0);
    do_read(4'h8, 0);
    do_read(4'hC, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
